// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types and constants for the p2s_stream serialiser.
// Parity enable follows the P2S_PARITY_EN macro.
package p2s_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
`ifdef P2S_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    function automatic int cnt_w(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction
endpackage

// File: rtl/p2s_hold.sv
// p2s_hold: one-entry holding buffer that parks a word while the shifter is busy.
module p2s_hold #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          full_o
);
    logic          full_q, full_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        full_d = push_i ? 1'b1 : pop_i ? 1'b0 : full_q;
        data_d = push_i ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;
endmodule

// File: rtl/p2s_stream.sv
// p2s_stream: DW-bit valid/ready words to a gap-free serial bit stream with sof/eof strobes.
// Define P2S_PARITY_EN to append an even-parity bit to every frame.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int   DW        = 8,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic          din_rdy,
    output logic          dout,
    output logic          dout_vld,
    output logic          sof,
    output logic          eof,
    output logic          busy
);
    localparam int FRAME_LEN = DW + (PAR_EN ? 1 : 0);
    localparam int CW = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] sh_q, sh_d, hold_data;
    logic          hold_full, last, free, xfer, load_new, load_hold, load, data_bit, bit_out;

    assign last      = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign xfer      = din_vld && !hold_full;
    // The shifter can take a fresh word only when nothing is queued ahead of it.
    assign free      = (state_q == IDLE) || (last && !hold_full);
    assign load_new  = xfer && free;
    assign load_hold = last && hold_full;
    assign load      = load_new || load_hold;

    p2s_hold #(.DW(DW)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (xfer && !free),
        .pop_i  (load_hold),
        .data_i (din),
        .data_o (hold_data),
        .full_o (hold_full)
    );

    always_comb begin
        state_d = load ? SHIFT : last ? IDLE : state_q;
        cnt_d   = (load || last) ? '0 : (state_q == SHIFT) ? cnt_q + 1'b1 : cnt_q;
        sh_d    = load_new ? din : load_hold ? hold_data :
                  (state_q == SHIFT) ? (MSB_FIRST ? {sh_q[DW-2:0], 1'b0} : {1'b0, sh_q[DW-1:1]}) : sh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    assign data_bit = MSB_FIRST ? sh_q[DW-1] : sh_q[0];

`ifdef P2S_PARITY_EN
    logic par_q, par_d;

    assign par_d = load_new ? ^din : load_hold ? ^hold_data : par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign bit_out = (cnt_q == CW'(DW)) ? par_q : data_bit;
`else
    assign bit_out = data_bit;
`endif

    assign dout_vld = (state_q == SHIFT);
    assign dout     = dout_vld ? bit_out : IDLE_LVL;
    assign sof      = dout_vld && (cnt_q == '0);
    assign eof      = last;
    assign busy     = dout_vld || hold_full;
    assign din_rdy  = !hold_full;
endmodule

// File: tb/tb_p2s_stream.sv
// tb_p2s_stream: scoreboard bench for p2s_stream; LSB-first and MSB-first instances share one stimulus.
// The reference model is a bit FIFO draining one bit per clock.
module tb_p2s_stream;
`ifdef P2S_PARITY_EN
    localparam int DW = 16;
    localparam int FL = DW + 1;
`else
    localparam int DW = 8;
    localparam int FL = DW;
`endif
    localparam logic IDLE_LVL = 1'b0;

    typedef struct {
        bit b0;
        bit b1;
        bit sof;
        bit eof;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_vld;
    logic          rdy0, dout0, vld0, sof0, eof0, busy0;
    logic          rdy1, dout1, vld1, sof1, eof1, busy1;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   xfer_m;

    always #5 clk = ~clk;

    p2s_stream #(.DW(DW), .MSB_FIRST(1'b0), .IDLE_LVL(IDLE_LVL)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(rdy0),
        .dout(dout0), .dout_vld(vld0), .sof(sof0), .eof(eof0), .busy(busy0)
    );

    p2s_stream #(.DW(DW), .MSB_FIRST(1'b1), .IDLE_LVL(IDLE_LVL)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(rdy1),
        .dout(dout1), .dout_vld(vld1), .sof(sof1), .eof(eof1), .busy(busy1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Accepted words are appended as bits; one bit leaves the front every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            xfer_m = din_vld && (q.size() <= FL);
            if (q.size() > 0) void'(q.pop_front());
            if (xfer_m) begin
                for (int i = 0; i < DW; i++)
                    q.push_back('{b0: din[i], b1: din[DW-1-i], sof: (i == 0), eof: (i == FL - 1)});
                if (FL > DW) q.push_back('{b0: ^din, b1: ^din, sof: 1'b0, eof: 1'b1});
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        bit   v;
        v = (q.size() > 0);
        e = v ? q[0] : '{b0: 1'b0, b1: 1'b0, sof: 1'b0, eof: 1'b0};
        chk("lsb_dout", dout0, v ? e.b0 : IDLE_LVL);
        chk("msb_dout", dout1, v ? e.b1 : IDLE_LVL);
        chk("lsb_vld", vld0, v);
        chk("msb_vld", vld1, v);
        chk("lsb_sof", sof0, e.sof);
        chk("msb_sof", sof1, e.sof);
        chk("lsb_eof", eof0, e.eof);
        chk("msb_eof", eof1, e.eof);
        chk("lsb_busy", busy0, v);
        chk("msb_busy", busy1, v);
        chk("lsb_rdy", rdy0, q.size() <= FL);
        chk("msb_rdy", rdy1, q.size() <= FL);
    end

    task automatic send(input logic [DW-1:0] w);
        int n;
        n = 0;
        din_vld = 1'b1;
        while (q.size() > FL && n < 100) begin
            din = DW'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=%0d exp<100 cycles", n);
        end
        din = w;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        din     = '0;
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send(DW'(8'hDC));
        idle(FL + 4);
        send(DW'(8'hA5));
        send(DW'(8'h3C));
        send(DW'(8'hFF));
        idle(3 * FL + 4);
        for (int i = 0; i < 6; i++) send(DW'($urandom));
        idle(2 * FL + 4);
        send(DW'(8'h0F));
        send(DW'($urandom));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_lsb_vld", vld0, 1'b0);
        chk("rst_msb_vld", vld1, 1'b0);
        chk("rst_lsb_dout", dout0, IDLE_LVL);
        chk("rst_msb_dout", dout1, IDLE_LVL);
        chk("rst_lsb_busy", busy0, 1'b0);
        chk("rst_lsb_rdy", rdy0, 1'b1);
        chk("rst_lsb_sof", sof0, 1'b0);
        chk("rst_lsb_eof", eof0, 1'b0);
        din_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send(DW'(8'h81));
        idle(FL + 4);
`ifdef P2S_PARITY_EN
        send(DW'(16'h0007));
        idle(FL + 4);
`endif
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(1, 4));
            send(DW'($urandom));
        end
        idle(3 * FL + 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
